axi4_lite_master: RTL and testbench

AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

---
 rtl/axi4_lite_master_if.sv | 73 +++++++
 rtl/axi4_lite_master.sv | 168 ++++++++++++++++
 tb/tb_axi4_lite_master.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_master_if.sv
// Command/response and AXI4-Lite channel bundle for axi4_lite_master.
// The master modport is the bridge's view; slave is the view of everything around it.
interface axi4_lite_master_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_wstrb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_resp;
    logic                  rsp_timeout;

    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_WIDTH-1:0] m_axi_wstrb;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        input  rsp_ready,
        output m_axi_awaddr, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        output rsp_ready,
        input  m_axi_awaddr, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding command-to-AXI4-Lite bridge. Define AXI4L_MASTER_TIMEOUT_EN to add a
// per-state handshake watchdog that ends a stuck transaction with SLVERR and rsp_timeout = 1.
module axi4_lite_master #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    axi4_lite_master_if.master bus
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StRsp
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  tmo_hit;

`ifdef AXI4L_MASTER_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;
    logic        tmo_flag_q;
    logic        waiting;
    logic        resp_hs;

    assign waiting = state_q inside {StWrReq, StWrResp, StRdReq, StRdResp};
    assign tmo_hit = waiting && (tmo_cnt_q == TIMEOUT_CYCLES - 32'd1);
    // A response arriving on the limit cycle wins over the timeout.
    assign resp_hs = (state_q == StWrResp && bus.m_axi_bvalid) ||
                     (state_q == StRdResp && bus.m_axi_rvalid);

    always_ff @(posedge clk) begin
        if (rst || state_d != state_q) begin
            tmo_cnt_q <= '0;
        end else if (waiting) begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_flag_q <= 1'b0;
        end else if (state_q != StRsp && state_d == StRsp) begin
            tmo_flag_q <= tmo_hit && !resp_hs;
        end
    end

    assign bus.rsp_timeout = tmo_flag_q;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign tmo_hit               = 1'b0;
    assign bus.rsp_timeout       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    addr_d    = bus.cmd_addr;
                    wdata_d   = bus.cmd_wdata;
                    wstrb_d   = bus.cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = bus.cmd_we ? StWrReq : StRdReq;
                end
            end
            StWrReq: begin
                // Each valid is low once its done flag is set, so ready alone marks the beat.
                aw_done_d = aw_done_q | bus.m_axi_awready;
                w_done_d  = w_done_q | bus.m_axi_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = StWrResp;
                end
            end
            StWrResp: begin
                if (bus.m_axi_bvalid) begin
                    rsp_resp_d  = bus.m_axi_bresp;
                    rsp_rdata_d = '0;
                    state_d     = StRsp;
                end
            end
            StRdReq: begin
                if (bus.m_axi_arready) begin
                    state_d = StRdResp;
                end
            end
            StRdResp: begin
                if (bus.m_axi_rvalid) begin
                    rsp_resp_d  = bus.m_axi_rresp;
                    rsp_rdata_d = bus.m_axi_rdata;
                    state_d     = StRsp;
                end
            end
            StRsp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Timeout only fires when the state would otherwise have stayed put.
        if (tmo_hit && state_d == state_q) begin
            state_d     = StRsp;
            rsp_resp_d  = 2'b10;
            rsp_rdata_d = '0;
        end
    end

    assign bus.cmd_ready     = (state_q == StIdle);
    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awvalid = (state_q == StWrReq) && !aw_done_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wvalid  = (state_q == StWrReq) && !w_done_q;
    assign bus.m_axi_bready  = (state_q == StWrResp);
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arvalid = (state_q == StRdReq);
    assign bus.m_axi_rready  = (state_q == StRdResp);
    assign bus.rsp_valid     = (state_q == StRsp);
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_resp      = rsp_resp_q;
endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master: configurable-delay memory slave, handshake monitor and
// hand-computed expectations for latency, payload, response codes and reset abort.
module tb_axi4_lite_master;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_lite_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave knobs
    int         aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic       b_stall = 1'b0;

    // Slave state
    int          aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic        got_aw, got_w, r_pend;
    logic [7:0]  wr_addr, rd_addr, a_addr;
    logic [31:0] wr_data, a_data;
    logic [3:0]  wr_strb, a_strb;
    logic        na, nw;
    logic [31:0] mem [0:255];

    initial for (int i = 0; i < 256; i++) mem[i] = '0;

    assign bus.m_axi_awready = (aw_cnt >= aw_delay);
    assign bus.m_axi_wready  = (w_cnt >= w_delay);
    assign bus.m_axi_arready = (ar_cnt >= ar_delay);

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; r_pend <= 1'b0;
            bus.m_axi_bvalid <= 1'b0; bus.m_axi_bresp <= 2'b00;
            bus.m_axi_rvalid <= 1'b0; bus.m_axi_rresp <= 2'b00; bus.m_axi_rdata <= '0;
        end else begin
            na     = got_aw | (bus.m_axi_awvalid & bus.m_axi_awready);
            nw     = got_w | (bus.m_axi_wvalid & bus.m_axi_wready);
            a_addr = (bus.m_axi_awvalid && bus.m_axi_awready) ? bus.m_axi_awaddr : wr_addr;
            a_data = (bus.m_axi_wvalid && bus.m_axi_wready) ? bus.m_axi_wdata : wr_data;
            a_strb = (bus.m_axi_wvalid && bus.m_axi_wready) ? bus.m_axi_wstrb : wr_strb;
            if (bus.m_axi_awvalid && bus.m_axi_awready) begin
                aw_cnt <= 0; wr_addr <= bus.m_axi_awaddr;
            end else if (bus.m_axi_awvalid) aw_cnt <= aw_cnt + 1;
            if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                w_cnt <= 0; wr_data <= bus.m_axi_wdata; wr_strb <= bus.m_axi_wstrb;
            end else if (bus.m_axi_wvalid) w_cnt <= w_cnt + 1;
            if (na && nw && !b_stall) begin
                for (int i = 0; i < 4; i++)
                    if (a_strb[i]) mem[a_addr][8*i +: 8] <= a_data[8*i +: 8];
                bus.m_axi_bvalid <= 1'b1;
                bus.m_axi_bresp  <= bresp_cfg;
                got_aw <= 1'b0; got_w <= 1'b0;
            end else begin
                got_aw <= na; got_w <= nw;
            end
            if (bus.m_axi_bvalid && bus.m_axi_bready) bus.m_axi_bvalid <= 1'b0;

            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                ar_cnt  <= 0;
                rd_addr <= bus.m_axi_araddr;
                if (r_delay == 0) begin
                    bus.m_axi_rvalid <= 1'b1;
                    bus.m_axi_rdata  <= mem[bus.m_axi_araddr];
                    bus.m_axi_rresp  <= rresp_cfg;
                end else begin
                    r_pend <= 1'b1; r_cnt <= 1;
                end
            end else if (bus.m_axi_arvalid) ar_cnt <= ar_cnt + 1;
            if (r_pend) begin
                if (r_cnt >= r_delay) begin
                    bus.m_axi_rvalid <= 1'b1;
                    bus.m_axi_rdata  <= mem[rd_addr];
                    bus.m_axi_rresp  <= rresp_cfg;
                    r_pend <= 1'b0;
                end else r_cnt <= r_cnt + 1;
            end
            if (bus.m_axi_rvalid && bus.m_axi_rready) bus.m_axi_rvalid <= 1'b0;
        end
    end

    // Monitor
    int          aw_cyc = 0, w_cyc = 0, ar_cyc = 0, ar_hs = 0, b_hs = 0, rsp_cyc = 0;
    logic [7:0]  last_awaddr = 8'hFF, last_araddr = 8'hFF, prev_awaddr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    logic        prev_awv = 1'b0, aw_unstable = 1'b0;

    always @(posedge clk) begin
        aw_cyc  <= aw_cyc + int'(bus.m_axi_awvalid);
        w_cyc   <= w_cyc + int'(bus.m_axi_wvalid);
        ar_cyc  <= ar_cyc + int'(bus.m_axi_arvalid);
        rsp_cyc <= rsp_cyc + int'(bus.rsp_valid);
        if (bus.m_axi_bvalid && bus.m_axi_bready) b_hs <= b_hs + 1;
        if (bus.m_axi_arvalid && bus.m_axi_arready) begin
            ar_hs <= ar_hs + 1; last_araddr <= bus.m_axi_araddr;
        end
        if (bus.m_axi_awvalid && bus.m_axi_awready) last_awaddr <= bus.m_axi_awaddr;
        if (bus.m_axi_wvalid && bus.m_axi_wready) begin
            last_wdata <= bus.m_axi_wdata; last_wstrb <= bus.m_axi_wstrb;
        end
        if (bus.m_axi_awvalid && prev_awv && bus.m_axi_awaddr != prev_awaddr) aw_unstable <= 1'b1;
        prev_awv    <= bus.m_axi_awvalid;
        prev_awaddr <= bus.m_axi_awaddr;
    end

    task automatic run_cmd(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input int hold, output int lat,
                           output logic [31:0] rd, output logic [1:0] rs, output logic to,
                           output logic stable, output logic rdy_after);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_addr = addr;
        bus.cmd_wdata = wd; bus.cmd_wstrb = st;
        bus.rsp_ready = (hold == 0);
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.cmd_wstrb = '0;
        lat = 1;
        while (!bus.rsp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        rd = bus.rsp_rdata; rs = bus.rsp_resp; to = bus.rsp_timeout;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_rdata !== rd || bus.rsp_resp !== rs || bus.cmd_ready)
                stable = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        rdy_after = bus.cmd_ready && !bus.rsp_valid;
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready,
                bus.m_axi_arvalid, bus.m_axi_rready, bus.rsp_valid};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat, s0, s1, s2;
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        to, stable, rdy;

        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.cmd_wstrb = '0; bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'(ctrl_vec()), 64'h40);
        check("reset_rdata", 64'(bus.rsp_rdata), 64'h0);
        check("reset_resp", 64'(bus.rsp_resp), 64'h0);
        check("reset_timeout", 64'(bus.rsp_timeout), 64'h0);
        rst = 1'b0;

        // Zero-wait write
        s0 = b_hs;
        run_cmd(1'b1, 8'h00, 32'hDEADBEEF, 4'hF, 0, lat, rd, rs, to, stable, rdy);
        check("wr0_latency", 64'(lat), 64'd3);
        check("wr0_resp", 64'(rs), 64'h0);
        check("wr0_rdata", 64'(rd), 64'h0);
        check("wr0_timeout", 64'(to), 64'h0);
        check("wr0_cmd_ready_c4", 64'(rdy), 64'h1);
        check("wr0_awaddr", 64'(last_awaddr), 64'h00);
        check("wr0_wdata", 64'(last_wdata), 64'hDEADBEEF);
        check("wr0_b_count", 64'(b_hs - s0), 64'd1);

        // Zero-wait read-back
        s0 = ar_hs;
        run_cmd(1'b0, 8'h00, 32'h0, 4'h0, 0, lat, rd, rs, to, stable, rdy);
        check("rd0_latency", 64'(lat), 64'd3);
        check("rd0_rdata", 64'(rd), 64'hDEADBEEF);
        check("rd0_resp", 64'(rs), 64'h0);
        check("rd0_araddr", 64'(last_araddr), 64'h00);
        check("rd0_ar_count", 64'(ar_hs - s0), 64'd1);

        // AW delayed by 3, W immediate, partial strobe
        aw_delay = 3;
        s0 = aw_cyc; s1 = w_cyc; s2 = b_hs;
        run_cmd(1'b1, 8'h10, 32'h12345678, 4'h3, 0, lat, rd, rs, to, stable, rdy);
        aw_delay = 0;
        check("wrd_latency", 64'(lat), 64'd6);
        check("wrd_aw_cycles", 64'(aw_cyc - s0), 64'd4);
        check("wrd_w_cycles", 64'(w_cyc - s1), 64'd1);
        check("wrd_b_count", 64'(b_hs - s2), 64'd1);
        check("wrd_aw_stable", 64'(aw_unstable), 64'h0);
        check("wrd_awaddr", 64'(last_awaddr), 64'h10);
        check("wrd_wstrb", 64'(last_wstrb), 64'h3);

        // SLVERR read, rvalid 5 cycles late, response back-pressured 2 cycles
        r_delay = 5; rresp_cfg = 2'b10;
        run_cmd(1'b0, 8'h10, 32'h0, 4'h0, 2, lat, rd, rs, to, stable, rdy);
        r_delay = 0; rresp_cfg = 2'b00;
        check("rdslv_latency", 64'(lat), 64'd8);
        check("rdslv_resp", 64'(rs), 64'h2);
        check("rdslv_rdata", 64'(rd), 64'h00005678);
        check("rdslv_stable", 64'(stable), 64'h1);
        check("rdslv_ready_after", 64'(rdy), 64'h1);

        // DECERR on a write passes through
        bresp_cfg = 2'b11;
        run_cmd(1'b1, 8'h20, 32'hA5A50F0F, 4'hF, 0, lat, rd, rs, to, stable, rdy);
        bresp_cfg = 2'b00;
        check("wrdec_resp", 64'(rs), 64'h3);

        // Reset while waiting for B
        b_stall = 1'b1;
        s0 = rsp_cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_addr = 8'h30;
        bus.cmd_wdata = 32'h11111111; bus.cmd_wstrb = 4'hF;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_in_wr_resp", 64'(ctrl_vec()), 64'h08);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ctrl", 64'(ctrl_vec()), 64'h40);
        rst = 1'b0; b_stall = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_rsp", 64'(rsp_cyc - s0), 64'd0);

        run_cmd(1'b0, 8'h20, 32'h0, 4'h0, 0, lat, rd, rs, to, stable, rdy);
        check("recover_latency", 64'(lat), 64'd3);
        check("recover_rdata", 64'(rd), 64'hA5A50F0F);

`ifdef AXI4L_MASTER_TIMEOUT_EN
        ar_delay = 1000;
        s0 = ar_cyc;
        run_cmd(1'b0, 8'h40, 32'h0, 4'h0, 0, lat, rd, rs, to, stable, rdy);
        ar_delay = 0;
        check("tmo_latency", 64'(lat), 64'd9);
        check("tmo_ar_cycles", 64'(ar_cyc - s0), 64'd8);
        check("tmo_flag", 64'(to), 64'h1);
        check("tmo_resp", 64'(rs), 64'h2);
        check("tmo_rdata", 64'(rd), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
